// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchroniser plus counter debounce FSM with press/release strobes.
// Define BUTTON_LONG_PRESS_EN to build the hold counter that drives long_press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = 16,
  parameter bit ACTIVE_LEVEL = 1'b1,
  parameter int LONG_CYCLES = 24'd10000000,
  parameter int LONG_W = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_raw,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t r_state;
  logic r_sync1, r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic r_level, r_press, r_release;
  logic w_pressed_s;
  assign w_pressed_s = (r_sync2 == ACTIVE_LEVEL);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= ~ACTIVE_LEVEL;
      r_sync2 <= ~ACTIVE_LEVEL;
      r_state <= IDLE;
      r_cnt <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1 <= button_raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        IDLE:
          if (w_pressed_s) begin
            r_state <= PRESS_WAIT;
            r_cnt <= CNT_W'(1);
          end
        PRESS_WAIT:
          if (!w_pressed_s) begin
            r_state <= IDLE;
            r_cnt <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= PRESSED;
            r_level <= 1'b1;
            r_press <= 1'b1;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        PRESSED:
          if (!w_pressed_s) begin
            r_state <= RELEASE_WAIT;
            r_cnt <= CNT_W'(1);
          end
        RELEASE_WAIT:
          if (w_pressed_s) begin
            r_state <= PRESSED;
            r_cnt <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= IDLE;
            r_level <= 1'b0;
            r_release <= 1'b1;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        default: begin
          r_state <= IDLE;
          r_cnt <= '0;
        end
      endcase
    end
  end
  assign button_level = r_level;
  assign press_pulse = r_press;
  assign release_pulse = r_release;
`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] HOLD_MAX = LONG_W'(LONG_CYCLES - 1);
  logic [LONG_W-1:0] r_hold;
  logic r_long;
  logic w_accept;
  assign w_accept = (r_state == PRESS_WAIT) && w_pressed_s && (r_cnt == CNT_MAX);
  // Saturating hold count; release-side bounce keeps counting so a long hold is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (w_accept) begin
        r_hold <= '0;
      end else if ((r_state == PRESSED || r_state == RELEASE_WAIT) && r_hold != HOLD_MAX) begin
        r_hold <= r_hold + 1'b1;
        r_long <= (r_hold + 1'b1 == HOLD_MAX);
      end
    end
  end
  assign long_press = r_long;
`else
  // Evaluates to 0 for every legal parameter set; keeps the long-press parameters referenced.
  assign long_press = (LONG_W == 0) && (LONG_CYCLES == 0);
`endif
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed vector table plus hand sequences, run on active-high and active-low instances.
module tb_button_debounce;
`ifdef BUTTON_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif
  typedef struct packed {
    logic rst_n;
    logic raw;
    logic [3:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic raw = 1'b0;
  logic raw_n;
  logic l0, p0, r0, g0, l1, p1, r1, g1;
  int checks = 0;
  int failures = 0;
  int overlap = 0;
  vec_t vecs[$];
  assign raw_n = ~raw;
  always #5 clk = ~clk;
  button_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LEVEL(1'b1), .LONG_CYCLES(10), .LONG_W(4)) u_ah (
    .clk(clk), .rst_n(rst_n), .button_raw(raw), .button_level(l0),
    .press_pulse(p0), .release_pulse(r0), .long_press(g0)
  );
  button_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LEVEL(1'b0), .LONG_CYCLES(10), .LONG_W(4)) u_al (
    .clk(clk), .rst_n(rst_n), .button_raw(raw_n), .button_level(l1),
    .press_pulse(p1), .release_pulse(r1), .long_press(g1)
  );
  always @(negedge clk) if ((p0 && r0) || (p1 && r1)) overlap++;
  task automatic add(input logic r, input logic b, input logic [3:0] e);
    vecs.push_back('{r, b, e});
  endtask
  task automatic rep(input int n, input logic r, input logic b, input logic [3:0] e);
    for (int i = 0; i < n; i++) add(r, b, e);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int ps[2], ls[2], lc[2], rs[2], rc[2];
    logic [3:0] lvl_lp;
    lvl_lp = {3'b100, LP_EN};
    // expected {level, press, release, long} after each edge
    rep(5, 0, 0, 4'b0000);
    rep(20, 1, 0, 4'b0000);
    rep(5, 1, 1, 4'b0000);
    add(1, 1, 4'b1100);
    rep(8, 1, 1, 4'b1000);
    add(1, 1, lvl_lp);
    rep(5, 1, 1, 4'b1000);
    rep(5, 1, 0, 4'b1000);
    add(1, 0, 4'b0010);
    rep(4, 1, 0, 4'b0000);
    rep(3, 1, 1, 4'b0000);
    rep(8, 1, 0, 4'b0000);
    rep(4, 1, 1, 4'b0000);
    add(1, 0, 4'b0000);
    add(1, 0, 4'b1100);
    rep(3, 1, 0, 4'b1000);
    add(1, 0, 4'b0010);
    rep(3, 1, 0, 4'b0000);
    rep(5, 1, 1, 4'b0000);
    add(1, 1, 4'b1100);
    rep(3, 1, 1, 4'b1000);
    rep(3, 1, 0, 4'b1000);
    rep(2, 1, 1, 4'b1000);
    add(1, 1, lvl_lp);
    rep(3, 1, 1, 4'b1000);
    rep(5, 1, 0, 4'b1000);
    add(1, 0, 4'b0010);
    rep(3, 1, 0, 4'b0000);
    add(1, 1, 4'b0000);
    add(1, 0, 4'b0000);
    rep(2, 1, 1, 4'b0000);
    add(1, 0, 4'b0000);
    rep(5, 1, 1, 4'b0000);
    add(1, 1, 4'b1100);
    rep(2, 1, 1, 4'b1000);
    rep(5, 1, 0, 4'b1000);
    add(1, 0, 4'b0010);
    rep(3, 1, 0, 4'b0000);
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      raw = vecs[i].raw;
      tick();
      chk($sformatf("vec%0d_ah", i), {l0, p0, r0, g0}, vecs[i].exp);
      chk($sformatf("vec%0d_al", i), {l1, p1, r1, g1}, vecs[i].exp);
    end
    // long hold: press at step 5, long strobe 9 clocks later when built
    ps = '{-1, -1}; ls = '{-1, -1}; lc = '{0, 0}; rs = '{-1, -1};
    raw = 1'b1;
    for (int s = 0; s < 40; s++) begin
      tick();
      if (p0 && ps[0] < 0) ps[0] = s;
      if (p1 && ps[1] < 0) ps[1] = s;
      if (g0) begin lc[0]++; ls[0] = s; end
      if (g1) begin lc[1]++; ls[1] = s; end
    end
    raw = 1'b0;
    for (int s = 0; s < 20; s++) begin
      tick();
      if (r0 && rs[0] < 0) rs[0] = s;
      if (r1 && rs[1] < 0) rs[1] = s;
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("long_press_step_%0d", d), ps[d], 5);
      chk($sformatf("long_count_%0d", d), lc[d], LP_EN ? 1 : 0);
      chk($sformatf("long_step_%0d", d), ls[d], LP_EN ? 14 : -1);
      chk($sformatf("long_release_step_%0d", d), rs[d], 5);
    end
    // reset while held in PRESSED, then the held button re-presses
    ps = '{-1, -1}; rc = '{0, 0};
    raw = 1'b1;
    for (int s = 0; s < 13; s++) begin
      tick();
      if (p0 && ps[0] < 0) ps[0] = s;
      if (p1 && ps[1] < 0) ps[1] = s;
    end
    chk("rst_pre_press_ah", ps[0], 5);
    chk("rst_pre_press_al", ps[1], 5);
    chk("rst_pre_level", {l0, l1}, 2'b11);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_ah", {l0, p0, r0, g0}, 4'b0000);
    chk("rst_mid_al", {l1, p1, r1, g1}, 4'b0000);
    rst_n = 1'b1;
    ps = '{-1, -1};
    for (int s = 0; s < 12; s++) begin
      tick();
      if (p0 && ps[0] < 0) ps[0] = s;
      if (p1 && ps[1] < 0) ps[1] = s;
      if (r0) rc[0]++;
      if (r1) rc[1]++;
    end
    chk("rst_repress_ah", ps[0], 5);
    chk("rst_repress_al", ps[1], 5);
    chk("rst_no_release", rc[0] + rc[1], 0);
    chk("rst_level_after", {l0, l1}, 2'b11);
    chk("no_pulse_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Upstream conditioning stage for the board push-button.
- Path: raw pin → 2-FF synchroniser → counter-based debounce FSM → clean level plus single-cycle press/release strobes.
- Outputs feed the button-driven LED/exit logic that runs in the same `clk` domain, so that stage no longer samples a bouncing pin directly.
- Optional long-press strobe.

Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable samples required to accept a level change. Minimum legal value 2.
- `CNT_W`, default 16: debounce counter width. Must satisfy 2^CNT_W > `DEBOUNCE_CYCLES`.
- `ACTIVE_LEVEL`, default 1: raw pin level that means "pressed".
- `LONG_CYCLES`, default 24'd10000000: hold time in clocks for the long-press strobe. Used only with the optional feature.
- `LONG_W`, default 24: hold counter width. Must satisfy 2^LONG_W > `LONG_CYCLES`.

Ports:
- `clk` in 1: system clock, the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `button_raw` in 1: asynchronous raw button pin.
- `button_level` out 1: debounced state, 1 = pressed.
- `press_pulse` out 1: one-cycle strobe when `button_level` rises.
- `release_pulse` out 1: one-cycle strobe when `button_level` falls.
- `long_press` out 1: one-cycle long-press strobe. Port is always present.

Behaviour:
- **Clocking and reset:** one clock, `clk`. Reset is synchronous, active-low, on `rst_n`; it is sampled only on the `clk` rising edge.
- **Reset values:**
  - Sync FFs load the released level (~`ACTIVE_LEVEL`).
  - FSM goes to IDLE; all counters are 0.
  - `button_level`, `press_pulse`, `release_pulse` and `long_press` are all 0.
- **Synchroniser:** `button_raw` passes through sync1 then sync2. `pressed_s` = (sync2 == `ACTIVE_LEVEL`). No other logic touches `button_raw`.
- **FSM states:** IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: if `pressed_s`, go to PRESS_WAIT with cnt = 1. Otherwise stay.
  - PRESS_WAIT, `pressed_s` = 0: return to IDLE, cnt = 0, no strobe.
  - PRESS_WAIT, `pressed_s` = 1 and cnt == `DEBOUNCE_CYCLES`-1: go to PRESSED, `button_level` = 1, `press_pulse` = 1 for one cycle, cnt = 0.
  - PRESS_WAIT, otherwise: cnt++.
  - PRESSED: if !`pressed_s`, go to RELEASE_WAIT with cnt = 1.
  - RELEASE_WAIT: mirror of PRESS_WAIT.
    - `pressed_s` back to 1: return to PRESSED silently.
    - `DEBOUNCE_CYCLES` consecutive released samples: go to IDLE, `button_level` = 0, `release_pulse` = 1 for one cycle.
- **Latency:** if `button_raw` is first sampled pressed at edge k and stays pressed, `button_level` and `press_pulse` go high after edge k+1+`DEBOUNCE_CYCLES`. Release is symmetric.
- **Pulses:**
  - Registered, exactly one cycle wide, coincident with the `button_level` change.
  - `press_pulse` and `release_pulse` are never high together.
  - Between two strobes of the same kind there is always a strobe of the other kind.
- **Glitch rejection:** any excursion shorter than `DEBOUNCE_CYCLES` samples produces no output change and clears cnt.
- **Counter:** cnt never exceeds `DEBOUNCE_CYCLES`-1. There is no wrap-around path.
- **Reset mid-operation:**
  - Any state returns to IDLE and the outputs drop to 0 after the reset edge.
  - No `release_pulse` is emitted for a press that reset aborts.
  - A button still held when `rst_n` is released is treated as a new press: `press_pulse` follows after the normal latency.

Optional Feature:
- Macro: `BUTTON_LONG_PRESS_EN`.
- **Defined:**
  - A hold counter clears on entry to PRESSED and increments each cycle spent in PRESSED or RELEASE_WAIT. It saturates and does not wrap.
  - When it reaches `LONG_CYCLES`-1, `long_press` = 1 for one cycle, at most once per accepted press.
  - Bounce inside RELEASE_WAIT does not clear the hold counter.
  - The counter re-arms only when the FSM returns to IDLE.
- **Undefined:** `long_press` is tied to 0 and no hold counter is built.

Test Plan:
1. Reset held 5 clocks, `button_raw` released, `DEBOUNCE_CYCLES`=4 → all outputs 0 during reset and for 20 clocks after.
2. Clean press, `DEBOUNCE_CYCLES`=4: `button_raw`=1 sampled at edge 10 → `button_level` 1 and `press_pulse` high for exactly one cycle after edge 15. Release sampled at edge 30 → `button_level` 0 and `release_pulse` one cycle after edge 35.
3. Bounce pattern 1,0,1,1,0 (one clock each) then steady 1 → exactly one `press_pulse`, issued 5 clocks after the last 0→1 sample, and no `release_pulse`.
4. 3-clock high glitch with `DEBOUNCE_CYCLES`=4 → `button_level`, `press_pulse` and `release_pulse` stay 0.
5. With `BUTTON_LONG_PRESS_EN` defined, `LONG_CYCLES`=10, press held 40 clocks → one `long_press` strobe 9 clocks after `press_pulse`. Without the macro, `long_press` stays 0.
6. `rst_n` low for one edge while in PRESSED with the button held → outputs 0 after that edge, no `release_pulse`. After reset release, `press_pulse` fires again after 1+`DEBOUNCE_CYCLES` clocks. Repeat with `ACTIVE_LEVEL`=0 and inverted stimulus → identical response.
